vpp_meas_ctrl: RTL and testbench
================================

VPP_MEAS_CTRL -- requirements
Module: vpp_meas_ctrl

Interface
REQ-001 Parameter DW, default 10, sample width in bits.
REQ-002 Parameter WIN_LEN, default 1024, accepted samples per acquisition window (>=2).
REQ-003 Parameter SETTLE_LEN, default 256, clock cycles waited after any gain change (>=1).
REQ-004 Parameter HI_TH, default 900, span at or above which the block ranges down (less gain).
REQ-005 Parameter LO_TH, default 200, span below which the block ranges up (more gain).
REQ-006 Port clk  in  1  sole clock; one clock domain, all logic on its rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port enable  in  1  level; 1 = run continuous measurements, 0 = stop.
REQ-009 Port adc_data  in  DW  unsigned ADC sample.
REQ-010 Port adc_valid  in  1  adc_data valid this cycle.
REQ-011 Port gain_sel  out  2  front-end gain code, 0 = lowest gain, 3 = highest.
REQ-012 Port span  out  DW  measured max-min of the reported window.
REQ-013 Port range  out  2  gain_sel value in force during the reported window.
REQ-014 Port overrange  out  1  reported window clipped at gain 0.
REQ-015 Port res_valid  out  1  result valid (valid/ready handshake to BCD/display stage).
REQ-016 Port res_ready  in  1  downstream accepts result.
REQ-017 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SETTLE, ACQ, EVAL, REPORT; busy = (state != IDLE).
REQ-019 IDLE -> SETTLE when enable=1; SETTLE SHALL last exactly SETTLE_LEN cycles, then ACQ.
REQ-020 On ACQ entry, max SHALL load 0, min SHALL load 2^DW-1, sample counter SHALL load 0, clip flag SHALL clear.
REQ-021 In ACQ, each cycle with adc_valid=1 SHALL update max and min independently (one sample may update both), set clip if sample equals 0 or 2^DW-1, and increment the counter; adc_valid=0 cycles SHALL change nothing.
REQ-022 The WIN_LEN-th accepted sample SHALL be included, and the FSM SHALL enter EVAL on the same edge.
REQ-023 EVAL SHALL last one cycle and compute span = max-min, DW-bit unsigned, no wrap (max>=min is guaranteed).
REQ-024 EVAL decision, first match wins: (a) (span>=HI_TH or clip) and gain_sel>0 -> gain_sel-1, go SETTLE; (b) span<LO_TH and gain_sel<3 and not clip -> gain_sel+1, go SETTLE; (c) otherwise go REPORT.
REQ-025 Consecutive range changes without an intervening REPORT SHALL be capped at 3; on the 4th request EVAL SHALL go REPORT with gain unchanged.
REQ-026 REPORT entry SHALL load span, range=gain_sel, overrange=(clip and gain_sel==0), and assert res_valid.
REQ-027 res_valid rises on the second rising edge after the edge accepting the last window sample.
REQ-028 While res_valid=1 and res_ready=0, span/range/overrange SHALL hold stable and ADC samples SHALL be ignored.
REQ-029 Transfer occurs on an edge with res_valid=1 and res_ready=1; res_valid SHALL drop that edge, the range-change counter SHALL clear, and the FSM SHALL go ACQ if enable=1 (no settle, gain unchanged), else IDLE.
REQ-030 enable=0 in SETTLE, ACQ or EVAL SHALL abort to IDLE on the next edge with no result and gain_sel retained; enable=0 in REPORT SHALL NOT abort, completing the handshake first.
REQ-031 gain_sel SHALL change only on the EVAL->SETTLE edge and never leave 0..3.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, gain_sel=0, span=0, range=0, overrange=0, res_valid=0, busy=0, counters and range-change count 0, at any point including mid-ACQ or mid-handshake.
REQ-033 After rst deasserts, first activity SHALL be IDLE->SETTLE on an edge with enable=1.

Verification (WIN_LEN=8, SETTLE_LEN=4, HI_TH=900, LO_TH=200)
REQ-034 enable=1, 8 valid samples spanning 300..800 at gain 0 -> res_valid 2 edges after 8th sample, span=500, range=0, overrange=0.
REQ-035 ADC model whose span doubles per gain step, base span 40 -> gain_sel steps 1,2,3 with 4-cycle settle each, then report span=320, range=3.
REQ-036 Window containing 1023 at gain 0 -> report overrange=1, range=0, no gain change.
REQ-037 res_ready held 0 for 10 cycles during REPORT while ADC toggles -> res_valid and outputs stable, then one transfer and immediate ACQ.
REQ-038 enable dropped after 5th sample -> IDLE next edge, res_valid never asserted; rst pulsed mid-ACQ -> all REQ-032 values at once.
REQ-039 Model alternating clip/low-span per gain -> exactly 3 range changes, then report at current gain.

Source files
------------

// File: rtl/vpp_meas_ctrl_if.sv
// Signal bundle for the peak-to-peak measurement controller: ADC stream in,
// autorange gain code out, result valid/ready handshake towards the display stage.
interface vpp_meas_ctrl_if #(
  parameter int DW = 10
);
  logic          enable;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [1:0]    gain_sel;
  logic [DW-1:0] span;
  logic [1:0]    range;
  logic          overrange;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  modport master (
    output enable, adc_data, adc_valid, res_ready,
    input  gain_sel, span, range, overrange, res_valid, busy
  );

  modport slave (
    input  enable, adc_data, adc_valid, res_ready,
    output gain_sel, span, range, overrange, res_valid, busy
  );
endinterface

// File: rtl/vpp_meas_ctrl.sv
// Autoranging peak-to-peak measurement: settle after gain changes, track max/min
// over a fixed sample window, step gain toward a usable span, then hand off the result.
module vpp_meas_ctrl #(
  parameter int DW         = 10,
  parameter int WIN_LEN    = 1024,
  parameter int SETTLE_LEN = 256,
  parameter int HI_TH      = 900,
  parameter int LO_TH      = 200
) (
  input  logic           clk,
  input  logic           rst,
  vpp_meas_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACQ,
    EVAL,
    REPORT
  } state_t;

  localparam int SW = $clog2(SETTLE_LEN + 1);
  localparam int CW = $clog2(WIN_LEN + 1);

  localparam logic [DW-1:0] FULL_SCALE  = {DW{1'b1}};
  localparam logic [DW:0]   HI_V        = (DW+1)'(HI_TH);
  localparam logic [DW:0]   LO_V        = (DW+1)'(LO_TH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_LEN - 1);

  state_t        state_reg;
  logic [SW-1:0] settle_cnt_reg;
  logic [CW-1:0] smp_cnt_reg;
  logic [DW-1:0] max_reg;
  logic [DW-1:0] min_reg;
  logic          clip_reg;
  logic [1:0]    chg_cnt_reg;
  logic [1:0]    gain_reg;
  logic [DW-1:0] span_reg;
  logic [1:0]    range_reg;
  logic          ovr_reg;
  logic          res_valid_reg;

  logic [DW-1:0] win_span;
  logic [DW-1:0] max_next;
  logic [DW-1:0] min_next;
  logic          smp_clip;
  logic          go_down;
  logic          go_up;
  logic          chg_allowed;

  always_comb begin
    win_span    = max_reg - min_reg;
    max_next    = (bus.adc_data > max_reg) ? bus.adc_data : max_reg;
    min_next    = (bus.adc_data < min_reg) ? bus.adc_data : min_reg;
    smp_clip    = (bus.adc_data == '0) || (bus.adc_data == FULL_SCALE);
    // Ranging down has priority; a clipped window never asks for more gain.
    go_down     = (({1'b0, win_span} >= HI_V) || clip_reg) && (gain_reg != 2'd0);
    go_up       = !go_down && ({1'b0, win_span} < LO_V) && (gain_reg != 2'd3) && !clip_reg;
    chg_allowed = (chg_cnt_reg != 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      smp_cnt_reg    <= '0;
      max_reg        <= '0;
      min_reg        <= '0;
      clip_reg       <= 1'b0;
      chg_cnt_reg    <= 2'd0;
      gain_reg       <= 2'd0;
      span_reg       <= '0;
      range_reg      <= 2'd0;
      ovr_reg        <= 1'b0;
      res_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.enable) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= '0;
          end
        end

        SETTLE: begin
          if (!bus.enable) begin
            state_reg <= IDLE;
          end else if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg   <= ACQ;
            max_reg     <= '0;
            min_reg     <= FULL_SCALE;
            smp_cnt_reg <= '0;
            clip_reg    <= 1'b0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        ACQ: begin
          if (!bus.enable) begin
            state_reg <= IDLE;
          end else if (bus.adc_valid) begin
            max_reg     <= max_next;
            min_reg     <= min_next;
            clip_reg    <= clip_reg | smp_clip;
            smp_cnt_reg <= smp_cnt_reg + 1'b1;
            if (smp_cnt_reg == WIN_LAST) begin
              state_reg <= EVAL;
            end
          end
        end

        EVAL: begin
          if (!bus.enable) begin
            state_reg <= IDLE;
          end else if ((go_down || go_up) && chg_allowed) begin
            gain_reg       <= go_down ? (gain_reg - 2'd1) : (gain_reg + 2'd1);
            chg_cnt_reg    <= chg_cnt_reg + 2'd1;
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end else begin
            span_reg      <= win_span;
            range_reg     <= gain_reg;
            ovr_reg       <= clip_reg && (gain_reg == 2'd0);
            res_valid_reg <= 1'b1;
            state_reg     <= REPORT;
          end
        end

        REPORT: begin
          // Dropping enable here only takes effect once the result is taken.
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            chg_cnt_reg   <= 2'd0;
            if (bus.enable) begin
              state_reg   <= ACQ;
              max_reg     <= '0;
              min_reg     <= FULL_SCALE;
              smp_cnt_reg <= '0;
              clip_reg    <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gain_sel  = gain_reg;
  assign bus.span      = span_reg;
  assign bus.range     = range_reg;
  assign bus.overrange = ovr_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_vpp_meas_ctrl.sv
// Randomized bench for vpp_meas_ctrl: a window-level reference model decides each
// window's outcome (range change or report) and the DUT is checked against it.
module tb_vpp_meas_ctrl;

  localparam int DW   = 10;
  localparam int WIN  = 8;
  localparam int SET  = 4;
  localparam int HI   = 900;
  localparam int LO   = 200;
  localparam int MAXV = 1023;

  logic clk = 1'b0;
  logic rst;

  vpp_meas_ctrl_if #(.DW(DW)) bus ();

  vpp_meas_ctrl #(
    .DW(DW), .WIN_LEN(WIN), .SETTLE_LEN(SET), .HI_TH(HI), .LO_TH(LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_gain = 0;
  int m_chg = 0;
  int e_span, e_range, e_ovr;
  int smp[WIN];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Samples the bench treats as garbage: full-scale or zero, so any wrongly accepted one shows up as clip.
  task automatic junk(input int n, input bit vld_rand);
    for (int k = 0; k < n; k++) begin
      bus.adc_valid = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.adc_data  = ($urandom_range(0, 1) != 0) ? DW'(MAXV) : DW'(0);
      step();
    end
  endtask

  // ADC front-end model; signal amplitude scales with 2^gain.
  function automatic int plant(input int kind, input int g, input int i, input int ctr, input int amp);
    int v;
    case (kind)
      0: v = 300 + (i * 500) / 7;
      1: v = (i % 2 != 0) ? 500 + (20 * (1 << g)) : 500 - (20 * (1 << g));
      2: v = (i == 3) ? MAXV : 400 + 10 * i;
      3: v = (g % 2 != 0) ? ((i == 5) ? 0 : 600 + 5 * i) : 500 + 10 * i;
      default: v = ctr + (int'($urandom_range(0, 2 * amp)) - amp) * (1 << g);
    endcase
    if (v < 0) v = 0;
    if (v > MAXV) v = MAXV;
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    chk_eq({tag, "_rv"}, int'(bus.res_valid), 1);
    chk_eq({tag, "_span"}, int'(bus.span), e_span);
    chk_eq({tag, "_range"}, int'(bus.range), e_range);
    chk_eq({tag, "_ovr"}, int'(bus.overrange), e_ovr);
    chk_eq({tag, "_gain"}, int'(bus.gain_sel), m_gain);
  endtask

  task automatic run_window(input int kind, input int ctr, input int amp, output bit rep);
    int mx, mn, sp;
    bit clip, dn, up;
    mx = 0; mn = MAXV; clip = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      smp[i] = plant(kind, m_gain, i, ctr, amp);
      if (smp[i] > mx) mx = smp[i];
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] == 0 || smp[i] == MAXV) clip = 1'b1;
    end
    for (int i = 0; i < WIN; i++) begin
      for (int gp = int'($urandom_range(0, 2)); gp > 0; gp--) begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = ($urandom_range(0, 1) != 0) ? DW'(MAXV) : DW'(0);
        step();
      end
      bus.adc_valid = 1'b1;
      bus.adc_data  = DW'(smp[i]);
      step();
    end
    bus.adc_valid = 1'b0;
    chk_eq("eval_rv", int'(bus.res_valid), 0);
    chk_eq("eval_busy", int'(bus.busy), 1);
    chk_eq("eval_gain", int'(bus.gain_sel), m_gain);
    sp = mx - mn;
    dn = (sp >= HI || clip) && m_gain > 0;
    up = !dn && sp < LO && m_gain < 3 && !clip;
    step();
    if ((dn || up) && m_chg < 3) begin
      m_gain = dn ? m_gain - 1 : m_gain + 1;
      m_chg++;
      rep = 1'b0;
      chk_eq("chg_gain", int'(bus.gain_sel), m_gain);
      chk_eq("chg_rv", int'(bus.res_valid), 0);
      chk_eq("chg_busy", int'(bus.busy), 1);
    end else begin
      rep = 1'b1;
      e_span  = sp;
      e_range = m_gain;
      e_ovr   = (clip && m_gain == 0) ? 1 : 0;
      check_outputs("rep");
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk_eq({tag, "_busy"}, int'(bus.busy), 0);
    chk_eq({tag, "_gain"}, int'(bus.gain_sel), 0);
    chk_eq({tag, "_span"}, int'(bus.span), 0);
    chk_eq({tag, "_range"}, int'(bus.range), 0);
    chk_eq({tag, "_ovr"}, int'(bus.overrange), 0);
    chk_eq({tag, "_rv"}, int'(bus.res_valid), 0);
    m_gain = 0;
    m_chg  = 0;
    bus.res_ready = 1'b0;
    bus.adc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      junk(1, 1'b1);
      chk_eq({tag, "_idle"}, int'(bus.busy), 0);
    end
  endtask

  task automatic start_run();
    bus.enable = 1'b1;
    junk(1 + SET, 1'b0);
  endtask

  task automatic measure(input int kind, input int ctr, input int amp, input int hold,
                         input bit drop_en, input int rst_at);
    bit rep;
    for (int w = 0; w < 5; w++) begin
      run_window(kind, ctr, amp, rep);
      if (!rep) begin
        junk(SET, 1'b0);
        continue;
      end
      if (drop_en) bus.enable = 1'b0;
      for (int h = 0; h < hold; h++) begin
        if (h == rst_at) begin
          async_reset_check("rst_hs");
          return;
        end
        bus.res_ready = 1'b0;
        junk(1, 1'b1);
        check_outputs("hold");
      end
      bus.res_ready = 1'b1;
      junk(1, 1'b1);
      bus.res_ready = 1'b0;
      chk_eq("xfer_rv", int'(bus.res_valid), 0);
      chk_eq("xfer_busy", int'(bus.busy), drop_en ? 0 : 1);
      m_chg = 0;
      $display("report kind=%0d span=%0d range=%0d overrange=%0d", kind, e_span, e_range, e_ovr);
      return;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.enable    = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    bus.res_ready = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_eq("rst_busy", int'(bus.busy), 0);
    chk_eq("rst_gain", int'(bus.gain_sel), 0);
    chk_eq("rst_span", int'(bus.span), 0);
    chk_eq("rst_range", int'(bus.range), 0);
    chk_eq("rst_ovr", int'(bus.overrange), 0);
    chk_eq("rst_rv", int'(bus.res_valid), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      junk(1, 1'b1);
      chk_eq("idle_off", int'(bus.busy), 0);
    end

    start_run();
    measure(0, 0, 0, 2, 1'b0, -1);
    measure(2, 0, 0, 0, 1'b0, -1);
    measure(1, 0, 0, 10, 1'b0, -1);
    measure(3, 0, 0, 1, 1'b0, -1);
    for (int r = 0; r < 10; r++) begin
      measure(4, int'($urandom_range(100, 923)), int'($urandom_range(5, 300)),
              int'($urandom_range(1, 4)), (r == 9), -1);
    end

    // Abort mid-window: back to IDLE on the next edge, no result.
    start_run();
    for (int i = 0; i < 5; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = DW'(500 + i);
      step();
    end
    bus.enable = 1'b0;
    step();
    chk_eq("abort_busy", int'(bus.busy), 0);
    chk_eq("abort_gain", int'(bus.gain_sel), m_gain);
    for (int k = 0; k < 4; k++) begin
      junk(1, 1'b1);
      chk_eq("abort_rv", int'(bus.res_valid), 0);
    end

    // Reset mid-acquisition with nonzero gain and result registers.
    start_run();
    measure(1, 0, 0, 3, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = DW'(450 + i);
      step();
    end
    async_reset_check("rst_acq");

    start_run();
    measure(0, 0, 0, 6, 1'b0, 3);

    start_run();
    measure(0, 0, 0, 1, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
